// File: rtl/prefetch_writer.sv
// Instruction-fetch producer for the rv32i front-end FIFO: issues sequential fetches,
// writes responses into the FIFO, flushes on redirect. Optional: PREFETCH_DISCARD_CNT_EN.
module prefetch_writer #(
  parameter int          C_FIFO_DEPTH_X    = 2,
  parameter int          C_MAX_OUTSTANDING = 2,
  parameter logic [31:0] C_RESET_PC        = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        resetb_i,
  input  logic        clk_en_i,
  input  logic        jump_i,
  input  logic [31:0] jump_addr_i,
  output logic        ireqvalid_o,
  output logic [31:0] ireqaddr_o,
  input  logic        ireqready_i,
  input  logic        irspvalid_i,
  input  logic [31:0] irspdata_i,
  input  logic        irsperror_i,
  output logic        fifo_flush_o,
  output logic        fifo_wr_o,
  output logic [64:0] fifo_din_o,
  input  logic        fifo_rd_i
`ifdef PREFETCH_DISCARD_CNT_EN
  ,
  output logic [31:0] discard_cnt_o
`endif
);

  localparam int          LW    = C_FIFO_DEPTH_X + 1;
  localparam int          OW    = $clog2(C_MAX_OUTSTANDING + 1);
  localparam logic [31:0] DEPTH = 32'(1) << C_FIFO_DEPTH_X;
  localparam logic [31:0] MAXO  = 32'(C_MAX_OUTSTANDING);

  typedef enum logic {RUN, HALT} state_t;

  state_t          state_q, state_d;
  logic [31:0]     req_pc_q, req_pc_d;
  logic [31:0]     rsp_pc_q, rsp_pc_d;
  logic [31:0]     hold_addr_q, hold_addr_d;
  logic [LW-1:0]   level_q, level_d;
  logic [OW-1:0]   outst_q, outst_d;
  logic [OW-1:0]   discard_q, discard_d;
  logic            pending_q, pending_d;
  logic            stale_q, stale_d;
  logic            run_q;

  logic            jump_en;
  logic            credit_ok;
  logic            issue_ok;
  logic            req_valid;
  logic [31:0]     req_addr;
  logic            accept;
  logic            rsp;
  logic            keep;
  logic            drop;
  logic [31:0]     jump_target;
  logic            unusedJumpLsbs;

  assign unusedJumpLsbs = ^jump_addr_i[1:0];
  assign jump_target    = {jump_addr_i[31:2], 2'b00};

  // run_q keeps every output low until the first enabled edge after reset release
  assign jump_en   = jump_i & clk_en_i & run_q;
  assign credit_ok = ((32'(level_q) + 32'(outst_q)) < DEPTH) && (32'(outst_q) < MAXO);
  assign issue_ok  = run_q && (state_q == RUN) && credit_ok;
  assign req_valid = run_q & (issue_ok | pending_q);
  assign req_addr  = stale_q ? hold_addr_q : req_pc_q;
  assign accept    = req_valid & ireqready_i & clk_en_i;
  assign rsp       = irspvalid_i & clk_en_i & run_q;
  assign keep      = rsp & ~jump_i & (discard_q == '0);
  assign drop      = rsp & ~keep;

  assign ireqvalid_o  = req_valid;
  assign ireqaddr_o   = req_valid ? req_addr : 32'h0;
  assign fifo_flush_o = jump_en;
  assign fifo_wr_o    = keep;
  assign fifo_din_o   = keep ? {irsperror_i, rsp_pc_q, irspdata_i} : 65'h0;

  always_comb begin
    state_d     = state_q;
    req_pc_d    = req_pc_q;
    rsp_pc_d    = rsp_pc_q;
    hold_addr_d = hold_addr_q;
    stale_d     = stale_q;
    pending_d   = req_valid & ~ireqready_i;
    outst_d     = outst_q + OW'(accept) - OW'(rsp);
    level_d     = level_q + LW'(keep) - LW'(fifo_rd_i);
    discard_d   = discard_q - OW'(drop & (discard_q != '0)) + OW'(accept & stale_q);

    // A stale (pre-jump) request advances nothing in the new stream when accepted
    if (accept) begin
      stale_d = 1'b0;
      if (!stale_q) req_pc_d = req_pc_q + 32'd4;
    end

    if (keep) begin
      rsp_pc_d = rsp_pc_q + 32'd4;
      if (irsperror_i) state_d = HALT;
    end

    // Everything still in flight after a redirect belongs to the old stream
    if (jump_en) begin
      level_d   = '0;
      discard_d = outst_d;
      req_pc_d  = jump_target;
      rsp_pc_d  = jump_target;
      state_d   = RUN;
      if (req_valid && !ireqready_i) begin
        stale_d     = 1'b1;
        hold_addr_d = req_addr;
      end
    end
  end

  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state_q     <= RUN;
      req_pc_q    <= C_RESET_PC;
      rsp_pc_q    <= C_RESET_PC;
      hold_addr_q <= 32'h0;
      level_q     <= '0;
      outst_q     <= '0;
      discard_q   <= '0;
      pending_q   <= 1'b0;
      stale_q     <= 1'b0;
      run_q       <= 1'b0;
    end else if (clk_en_i) begin
      state_q     <= state_d;
      req_pc_q    <= req_pc_d;
      rsp_pc_q    <= rsp_pc_d;
      hold_addr_q <= hold_addr_d;
      level_q     <= level_d;
      outst_q     <= outst_d;
      discard_q   <= discard_d;
      pending_q   <= pending_d;
      stale_q     <= stale_d;
      run_q       <= 1'b1;
    end
  end

`ifdef PREFETCH_DISCARD_CNT_EN
  logic [31:0] discard_cnt_q;

  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      discard_cnt_q <= 32'h0;
    end else if (drop && (discard_cnt_q != 32'hFFFF_FFFF)) begin
      discard_cnt_q <= discard_cnt_q + 32'd1;
    end
  end

  assign discard_cnt_o = discard_cnt_q;
`endif

  a_rd_nonempty : assert property (@(posedge clk_i) disable iff (!resetb_i)
    (clk_en_i && fifo_rd_i && !jump_en) |-> (level_q != '0));
  a_rsp_outst : assert property (@(posedge clk_i) disable iff (!resetb_i)
    (clk_en_i && irspvalid_i) |-> (outst_q != '0));
  a_level_max : assert property (@(posedge clk_i) disable iff (!resetb_i)
    32'(level_q) <= DEPTH);
  a_outst_max : assert property (@(posedge clk_i) disable iff (!resetb_i)
    32'(outst_q) <= MAXO);
  a_discard_le : assert property (@(posedge clk_i) disable iff (!resetb_i)
    discard_q <= outst_q);

endmodule

// File: tb/tb_prefetch_writer.sv
// Directed, table-driven bench for prefetch_writer (D=4, two outstanding, 1-cycle bus).
module tb_prefetch_writer;

  logic        clk_i = 1'b0;
  logic        resetb_i;
  logic        clk_en_i;
  logic        jump_i;
  logic [31:0] jump_addr_i;
  logic        ireqvalid_o;
  logic [31:0] ireqaddr_o;
  logic        ireqready_i;
  logic        irspvalid_i;
  logic [31:0] irspdata_i;
  logic        irsperror_i;
  logic        fifo_flush_o;
  logic        fifo_wr_o;
  logic [64:0] fifo_din_o;
  logic        fifo_rd_i;
`ifdef PREFETCH_DISCARD_CNT_EN
  logic [31:0] discard_cnt_o;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  prefetch_writer #(
    .C_FIFO_DEPTH_X   (2),
    .C_MAX_OUTSTANDING(2),
    .C_RESET_PC       (32'h0000_0000)
  ) dut (
    .clk_i       (clk_i),
    .resetb_i    (resetb_i),
    .clk_en_i    (clk_en_i),
    .jump_i      (jump_i),
    .jump_addr_i (jump_addr_i),
    .ireqvalid_o (ireqvalid_o),
    .ireqaddr_o  (ireqaddr_o),
    .ireqready_i (ireqready_i),
    .irspvalid_i (irspvalid_i),
    .irspdata_i  (irspdata_i),
    .irsperror_i (irsperror_i),
    .fifo_flush_o(fifo_flush_o),
    .fifo_wr_o   (fifo_wr_o),
    .fifo_din_o  (fifo_din_o),
    .fifo_rd_i   (fifo_rd_i)
`ifdef PREFETCH_DISCARD_CNT_EN
    ,
    .discard_cnt_o(discard_cnt_o)
`endif
  );

  typedef struct {
    bit          rst;
    bit          rdy;
    bit          rspv;
    logic [31:0] rdata;
    bit          rerr;
    bit          rd;
    bit          jmp;
    logic [31:0] jaddr;
    bit          eValid;
    logic [31:0] eAddr;
    bit          eWr;
    logic [31:0] ePc;
    bit          eErr;
    bit          eFlush;
    int          eDisc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit rst, bit rdy, bit rspv, logic [31:0] rdata, bit rerr,
                              bit rd, bit jmp, logic [31:0] jaddr, bit eValid,
                              logic [31:0] eAddr, bit eWr, logic [31:0] ePc, bit eErr,
                              bit eFlush, int eDisc);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.rspv = rspv; v.rdata = rdata; v.rerr = rerr;
    v.rd = rd; v.jmp = jmp; v.jaddr = jaddr; v.eValid = eValid; v.eAddr = eAddr;
    v.eWr = eWr; v.ePc = ePc; v.eErr = eErr; v.eFlush = eFlush; v.eDisc = eDisc;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [64:0] act,
                     input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s vec=%0d actual=%h required=%h", name, idx, act, exp);
    end
  endtask

  task automatic idleInputs();
    clk_en_i    = 1'b1;
    jump_i      = 1'b0;
    jump_addr_i = 32'h0;
    ireqready_i = 1'b0;
    irspvalid_i = 1'b0;
    irspdata_i  = 32'h0;
    irsperror_i = 1'b0;
    fifo_rd_i   = 1'b0;
  endtask

  // Leaves the bench #1 after the first enabled edge following reset release
  task automatic resetTask(input int idx);
    idleInputs();
    resetb_i = 1'b0;
    @(negedge clk_i);
    chk("rst_ireqvalid", idx, 65'(ireqvalid_o), 65'h0);
    chk("rst_ireqaddr", idx, 65'(ireqaddr_o), 65'h0);
    chk("rst_fifo_wr", idx, 65'(fifo_wr_o), 65'h0);
    chk("rst_fifo_flush", idx, 65'(fifo_flush_o), 65'h0);
    chk("rst_fifo_din", idx, fifo_din_o, 65'h0);
    @(posedge clk_i);
    #1 resetb_i = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    clk_en_i    = 1'b1;
    ireqready_i = v.rdy;
    irspvalid_i = v.rspv;
    irspdata_i  = v.rdata;
    irsperror_i = v.rerr;
    fifo_rd_i   = v.rd;
    jump_i      = v.jmp;
    jump_addr_i = v.jaddr;
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    chk("ireqvalid", idx, 65'(ireqvalid_o), 65'(v.eValid));
    if (v.eValid) chk("ireqaddr", idx, 65'(ireqaddr_o), 65'(v.eAddr));
    chk("fifo_wr", idx, 65'(fifo_wr_o), 65'(v.eWr));
    if (v.eWr) chk("fifo_din", idx, fifo_din_o, {v.eErr, v.ePc, v.rdata});
    chk("fifo_flush", idx, 65'(fifo_flush_o), 65'(v.eFlush));
`ifdef PREFETCH_DISCARD_CNT_EN
    if (v.eDisc >= 0) chk("discard_cnt", idx, 65'(discard_cnt_o), 65'(v.eDisc));
`endif
  endtask

  initial begin
    idleInputs();
    resetb_i = 1'b0;

    // Fill to four entries, stall on full credit, one pop releases exactly one request
    tbl.push_back(mk(1,1,0,32'h0,        0,0,0,32'h0,   1,32'h0,  0,32'h0, 0,0,-1));
    tbl.push_back(mk(0,1,1,32'hAAAA_0000,0,0,0,32'h0,   1,32'h4,  1,32'h0, 0,0,-1));
    tbl.push_back(mk(0,1,1,32'hAAAA_0004,0,0,0,32'h0,   1,32'h8,  1,32'h4, 0,0,-1));
    tbl.push_back(mk(0,1,1,32'hAAAA_0008,0,0,0,32'h0,   1,32'hC,  1,32'h8, 0,0,-1));
    tbl.push_back(mk(0,1,1,32'hAAAA_000C,0,0,0,32'h0,   0,32'h0,  1,32'hC, 0,0,-1));
    tbl.push_back(mk(0,1,0,32'h0,        0,0,0,32'h0,   0,32'h0,  0,32'h0, 0,0,-1));
    tbl.push_back(mk(0,1,0,32'h0,        0,1,0,32'h0,   0,32'h0,  0,32'h0, 0,0,-1));
    tbl.push_back(mk(0,1,0,32'h0,        0,0,0,32'h0,   1,32'h10, 0,32'h0, 0,0,-1));
    tbl.push_back(mk(0,1,1,32'hAAAA_0010,0,0,0,32'h0,   0,32'h0,  1,32'h10,0,0,-1));
    tbl.push_back(mk(0,1,0,32'h0,        0,0,0,32'h0,   0,32'h0,  0,32'h0, 0,0,-1));
    // Jump to 0x103 with two old requests in flight
    tbl.push_back(mk(1,1,0,32'h0,        0,0,0,32'h0,   1,32'h0,  0,32'h0, 0,0,0));
    tbl.push_back(mk(0,1,0,32'h0,        0,0,0,32'h0,   1,32'h4,  0,32'h0, 0,0,-1));
    tbl.push_back(mk(0,1,0,32'h0,        0,0,1,32'h103, 0,32'h0,  0,32'h0, 0,1,-1));
    tbl.push_back(mk(0,1,1,32'hDEAD_0000,0,0,0,32'h0,   0,32'h0,  0,32'h0, 0,0,-1));
    tbl.push_back(mk(0,1,1,32'hDEAD_0004,0,0,0,32'h0,   1,32'h100,0,32'h0, 0,0,-1));
    tbl.push_back(mk(0,1,1,32'hBBBB_0100,0,0,0,32'h0,   1,32'h104,1,32'h100,0,0,2));
    // Jump to 0x200 while request 0x8 is stalled
    tbl.push_back(mk(1,1,0,32'h0,        0,0,0,32'h0,   1,32'h0,  0,32'h0, 0,0,0));
    tbl.push_back(mk(0,1,1,32'hCCCC_0000,0,0,0,32'h0,   1,32'h4,  1,32'h0, 0,0,-1));
    tbl.push_back(mk(0,0,1,32'hCCCC_0004,0,0,0,32'h0,   1,32'h8,  1,32'h4, 0,0,-1));
    tbl.push_back(mk(0,0,0,32'h0,        0,0,1,32'h200, 1,32'h8,  0,32'h0, 0,1,-1));
    tbl.push_back(mk(0,0,0,32'h0,        0,0,0,32'h0,   1,32'h8,  0,32'h0, 0,0,-1));
    tbl.push_back(mk(0,1,0,32'h0,        0,0,0,32'h0,   1,32'h8,  0,32'h0, 0,0,-1));
    tbl.push_back(mk(0,1,1,32'hDEAD_0008,0,0,0,32'h0,   1,32'h200,0,32'h0, 0,0,-1));
    tbl.push_back(mk(0,1,1,32'hCCCC_0200,0,0,0,32'h0,   1,32'h204,1,32'h200,0,0,1));
    // Error response at 0x4 halts fetching until a jump to 0x40
    tbl.push_back(mk(1,1,0,32'h0,        0,0,0,32'h0,   1,32'h0,  0,32'h0, 0,0,0));
    tbl.push_back(mk(0,1,1,32'hEEEE_0000,0,0,0,32'h0,   1,32'h4,  1,32'h0, 0,0,-1));
    tbl.push_back(mk(0,1,1,32'hEEEE_0004,1,0,0,32'h0,   1,32'h8,  1,32'h4, 1,0,-1));
    tbl.push_back(mk(0,1,1,32'hEEEE_0008,0,0,0,32'h0,   0,32'h0,  1,32'h8, 0,0,-1));
    tbl.push_back(mk(0,1,0,32'h0,        0,0,0,32'h0,   0,32'h0,  0,32'h0, 0,0,-1));
    tbl.push_back(mk(0,1,0,32'h0,        0,0,1,32'h40,  0,32'h0,  0,32'h0, 0,1,-1));
    tbl.push_back(mk(0,1,0,32'h0,        0,0,0,32'h0,   1,32'h40, 0,32'h0, 0,0,-1));
    tbl.push_back(mk(0,1,1,32'hEEEE_0040,0,0,0,32'h0,   1,32'h44, 1,32'h40,0,0,0));

    foreach (tbl[i]) begin
      if (tbl[i].rst) resetTask(i);
      applyStimulus(tbl[i]);
      @(negedge clk_i);
      checkOutput(tbl[i], i);
      @(posedge clk_i);
      #1;
    end

    // Clock enable low: no address advance and a jump is ignored
    resetTask(100);
    clk_en_i    = 1'b0;
    ireqready_i = 1'b1;
    @(negedge clk_i);
    chk("cen0_ireqvalid", 100, 65'(ireqvalid_o), 65'h1);
    chk("cen0_ireqaddr", 100, 65'(ireqaddr_o), 65'h0);
    @(posedge clk_i);
    #1 jump_i = 1'b1;
    jump_addr_i = 32'h0000_0300;
    @(negedge clk_i);
    chk("cen0_flush", 101, 65'(fifo_flush_o), 65'h0);
    chk("cen0_hold_addr", 101, 65'(ireqaddr_o), 65'h0);
    @(posedge clk_i);
    #1 jump_i = 1'b0;
    clk_en_i = 1'b1;
    @(negedge clk_i);
    chk("cen1_addr", 102, 65'(ireqaddr_o), 65'h0);
    @(posedge clk_i);
    #1 ireqready_i = 1'b0;
    @(negedge clk_i);
    chk("cen1_next_addr", 103, 65'(ireqaddr_o), 65'h4);

    // Reset mid-stream returns the fetch address to C_RESET_PC
    resetTask(104);
    @(negedge clk_i);
    chk("rerun_valid", 104, 65'(ireqvalid_o), 65'h1);
    chk("rerun_addr", 104, 65'(ireqaddr_o), 65'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
